// File: rtl/mem_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_bus_pkg : shared types, constants and helpers for mem_bus_arbiter |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mem_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_STORE = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  localparam int unsigned BURST_LEN_DEF  = 8;
  localparam int unsigned BLK_OFFS_W_DEF = $clog2(BURST_LEN_DEF * 4);

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Clears the byte offset within one burst-sized block.
  function automatic logic [63:0] blk_base(input logic [63:0] addr, input int unsigned offs_w);
    return addr & ~((64'd1 << offs_w) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_rr_arb : 2-way round-robin grant, pointer moves on completion     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_rr_arb
  import mem_bus_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_done,
  input  logic i_done_port,
  output logic o_gnt_vld,
  output logic o_gnt_port
);

  logic r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= PORT_I;
    end else if (i_done) begin
      r_last <= i_done_port;
    end
  end

  // On a tie the port opposite the last served one wins.
  always_comb begin
    o_gnt_vld = i_req_i | i_req_d;
    if (i_req_i && i_req_d) begin
      o_gnt_port = ~r_last;
    end else begin
      o_gnt_port = i_req_d ? PORT_D : PORT_I;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_bus_arbiter : shares one memory port between I-refill and D-cache |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_i_req,
  input  logic [ADDR_W-1:0] i_i_addr,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic [2:0]        o_ridx,
  output logic              o_i_rvalid,
  output logic              o_d_rvalid,
  output logic              o_i_done,
  output logic              o_d_done,
  output logic              o_err,
  output logic              o_m_valid,
  output logic              o_m_load,
  output logic              o_m_store,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic              o_m_addr_vld,
  output logic [DATA_W-1:0] o_m_wdata,
  output logic              o_m_wdata_vld,
  input  logic              i_m_ready,
  input  logic [DATA_W-1:0] i_m_rdata,
  input  logic              i_m_beat_vld,
  input  logic [2:0]        i_m_beat_idx,
  input  logic              i_m_wack
);

  localparam int unsigned OFFS_W   = $clog2(BURST_LEN * 4);
  localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [2:0]  LAST_IDX = 3'(BURST_LEN - 1);

  state_e r_state, w_state_nxt;

  logic [TMO_W-1:0]  r_tmo;
  logic              r_port, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_exp;

  logic [DATA_W-1:0] r_rdata, r_m_wdata;
  logic [2:0]        r_ridx;
  logic [ADDR_W-1:0] r_m_addr;
  logic r_i_rvalid, r_d_rvalid, r_i_done, r_d_done, r_err;
  logic r_m_valid, r_m_load, r_m_store, r_m_addr_vld, r_m_wdata_vld;

  logic              w_port, w_we;
  logic [ADDR_W-1:0] w_addr, w_m_addr;
  logic [DATA_W-1:0] w_wdata, w_rdata, w_m_wdata;
  logic [2:0]        w_exp, w_ridx;
  logic w_i_rvalid, w_d_rvalid, w_i_done, w_d_done, w_err;
  logic w_m_valid, w_m_load, w_m_store, w_m_addr_vld, w_m_wdata_vld;

  logic              w_gnt_vld, w_gnt_port;
  logic              w_tmo_hit, w_beat_ok, w_good, w_fin_enter, w_abort;
  logic [ADDR_W-1:0] w_load_base, w_store_addr;

  mem_rr_arb u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_i     (i_i_req),
    .i_req_d     (i_d_req),
    .i_done      (w_fin_enter),
    .i_done_port (r_port),
    .o_gnt_vld   (w_gnt_vld),
    .o_gnt_port  (w_gnt_port)
  );

  assign w_tmo_hit    = (r_tmo == TMO_W'(TIMEOUT));
  assign w_beat_ok    = (r_state == ST_LOAD) && i_m_beat_vld && (i_m_beat_idx == r_exp);
  assign w_good       = w_beat_ok || ((r_state == ST_STORE) && i_m_wack);
  assign w_fin_enter  = (w_state_nxt == ST_FIN) && (r_state != ST_FIN);
  assign w_abort      = w_fin_enter && !w_good;
  assign w_load_base  = ADDR_W'(blk_base(64'(r_addr), OFFS_W));
  assign w_store_addr = {r_addr[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_gnt_vld) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (i_m_ready)      w_state_nxt = ST_ADDR;
        else if (w_tmo_hit) w_state_nxt = ST_FIN;
      end
      ST_ADDR:  w_state_nxt = r_we ? ST_STORE : ST_LOAD;
      ST_LOAD: begin
        if (i_m_beat_vld) begin
          if (!w_beat_ok || (r_exp == LAST_IDX)) w_state_nxt = ST_FIN;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_STORE: if (i_m_wack || w_tmo_hit) w_state_nxt = ST_FIN;
      ST_FIN:   if (!i_m_ready || w_tmo_hit) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_port        = r_port;
    w_we          = r_we;
    w_addr        = r_addr;
    w_wdata       = r_wdata;
    w_exp         = r_exp;
    w_rdata       = r_rdata;
    w_ridx        = r_ridx;
    w_m_addr      = r_m_addr;
    w_m_wdata     = r_m_wdata;
    w_m_valid     = r_m_valid;
    w_m_load      = r_m_load;
    w_m_store     = r_m_store;
    w_m_addr_vld  = 1'b0;
    w_m_wdata_vld = 1'b0;
    w_i_rvalid    = 1'b0;
    w_d_rvalid    = 1'b0;
    w_i_done      = 1'b0;
    w_d_done      = 1'b0;
    w_err         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_port    = w_gnt_port;
          w_we      = (w_gnt_port == PORT_D) && i_d_we;
          w_addr    = (w_gnt_port == PORT_D) ? i_d_addr : i_i_addr;
          w_wdata   = i_d_wdata;
          w_exp     = 3'd0;
          w_m_valid = 1'b1;
          w_m_load  = !w_we;
          w_m_store = w_we;
        end
      end
      ST_REQ: begin
        if (w_state_nxt == ST_ADDR) begin
          w_m_addr     = r_we ? w_store_addr : w_load_base;
          w_m_addr_vld = 1'b1;
        end
      end
      ST_ADDR: begin
        if (r_we) begin
          w_m_wdata     = r_wdata;
          w_m_wdata_vld = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_beat_ok) begin
          w_rdata    = i_m_rdata;
          w_ridx     = i_m_beat_idx;
          w_i_rvalid = (r_port == PORT_I);
          w_d_rvalid = (r_port == PORT_D);
          w_exp      = r_exp + 3'd1;
        end
      end
      default: ;
    endcase
    if (w_fin_enter) begin
      w_m_valid = 1'b0;
      w_m_load  = 1'b0;
      w_m_store = 1'b0;
      w_i_done  = (r_port == PORT_I);
      w_d_done  = (r_port == PORT_D);
      w_err     = w_abort;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port        <= PORT_I;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_exp         <= 3'd0;
      r_rdata       <= '0;
      r_ridx        <= 3'd0;
      r_m_addr      <= '0;
      r_m_wdata     <= '0;
      r_m_valid     <= 1'b0;
      r_m_load      <= 1'b0;
      r_m_store     <= 1'b0;
      r_m_addr_vld  <= 1'b0;
      r_m_wdata_vld <= 1'b0;
      r_i_rvalid    <= 1'b0;
      r_d_rvalid    <= 1'b0;
      r_i_done      <= 1'b0;
      r_d_done      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_port        <= w_port;
      r_we          <= w_we;
      r_addr        <= w_addr;
      r_wdata       <= w_wdata;
      r_exp         <= w_exp;
      r_rdata       <= w_rdata;
      r_ridx        <= w_ridx;
      r_m_addr      <= w_m_addr;
      r_m_wdata     <= w_m_wdata;
      r_m_valid     <= w_m_valid;
      r_m_load      <= w_m_load;
      r_m_store     <= w_m_store;
      r_m_addr_vld  <= w_m_addr_vld;
      r_m_wdata_vld <= w_m_wdata_vld;
      r_i_rvalid    <= w_i_rvalid;
      r_d_rvalid    <= w_d_rvalid;
      r_i_done      <= w_i_done;
      r_d_done      <= w_d_done;
      r_err         <= w_err;
    end
  end

  // Restarts on every state change and every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if ((r_state == ST_IDLE) || (w_state_nxt != r_state) || w_beat_ok) begin
      r_tmo <= '0;
    end else if (!w_tmo_hit) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign o_rdata       = r_rdata;
  assign o_ridx        = r_ridx;
  assign o_i_rvalid    = r_i_rvalid;
  assign o_d_rvalid    = r_d_rvalid;
  assign o_i_done      = r_i_done;
  assign o_d_done      = r_d_done;
  assign o_err         = r_err;
  assign o_m_valid     = r_m_valid;
  assign o_m_load      = r_m_load;
  assign o_m_store     = r_m_store;
  assign o_m_addr      = r_m_addr;
  assign o_m_addr_vld  = r_m_addr_vld;
  assign o_m_wdata     = r_m_wdata;
  assign o_m_wdata_vld = r_m_wdata_vld;

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path (port I) and the data-cache path (port D).
- Arbitrates requests round-robin.
- Sequences the memory handshake: request, address phase, then either an 8-beat load burst or a single-word store.
- Returns load beats to the granted requester and flags protocol errors and timeouts.

Parameters:
- BURST_LEN, 8: words per load burst (power of two).
- ADDR_W, 32: byte-address width.
- DATA_W, 32: word width.
- TIMEOUT, 256: max cycles spent waiting on any single memory response before abort.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- I_REQ  in  1  I-side load request; held until I_DONE.
- I_ADDR  in  ADDR_W  I-side byte address; held with I_REQ.
- D_REQ  in  1  D-side request; held until D_DONE.
- D_WE  in  1  D-side 1=store, 0=load.
- D_ADDR  in  ADDR_W  D-side byte address.
- D_WDATA  in  DATA_W  D-side store data.
- RDATA  out  DATA_W  load beat data (shared by both ports).
- RIDX  out  3  load beat word index.
- I_RVALID / D_RVALID  out  1  beat valid for the granted port.
- I_DONE / D_DONE  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle pulse coincident with DONE on abort.
- M_VALID  out  1  transaction active toward memory.
- M_LOAD / M_STORE  out  1  operation, one-hot while M_VALID is high.
- M_ADDR  out  ADDR_W  address toward memory.
- M_ADDR_VLD  out  1  address strobe.
- M_WDATA  out  DATA_W  store data.
- M_WDATA_VLD  out  1  store data strobe.
- M_READY  in  1  memory accepted the transaction.
- M_RDATA  in  DATA_W  load beat data from memory.
- M_BEAT_VLD  in  1  load beat strobe.
- M_BEAT_IDX  in  3  load beat index.
- M_WACK  in  1  store written.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; every output 0; round-robin pointer=I; beat counter=0; timeout counter=0. Reset mid-transaction drops M_VALID immediately; the memory side must recover from M_VALID falling.
- All outputs are registered.
- States: IDLE, REQ, ADDR, LOAD, STORE, FIN.
- IDLE:
  - If any REQ is high, grant it.
  - If both are high, the port opposite the last-completed grant wins (pointer starts at I, so D wins the first tie).
  - Latch port, op, address and wdata. Next cycle: M_VALID=1, M_LOAD or M_STORE set, go to REQ. Request-to-M_VALID latency is one cycle.
  - I port is always a load.
- REQ: wait for M_READY=1. Then drive M_ADDR and M_ADDR_VLD=1 for exactly one cycle; go to ADDR.
  - Load address = block base = addr with low log2(BURST_LEN*4) bits cleared (addr & ~0x1F for defaults).
  - Store address = addr with bits[1:0] cleared.
- ADDR: one cycle.
  - Load: go to LOAD with expected index=0.
  - Store: drive M_WDATA and pulse M_WDATA_VLD one cycle; go to STORE.
- LOAD: on each M_BEAT_VLD:
  - If M_BEAT_IDX == expected: RDATA<=M_RDATA, RIDX<=idx, pulse the granted port's RVALID next cycle, increment expected.
  - Beat with idx==BURST_LEN-1 accepted: go to FIN.
  - Index mismatch: ERR, go to FIN.
  - Beats are delivered in index order; no beat is dropped or duplicated.
- STORE: on M_WACK go to FIN.
- FIN:
  - M_VALID, M_LOAD, M_STORE <= 0.
  - Pulse the granted port's DONE (plus ERR if aborting).
  - Flip the round-robin pointer away from the served port.
  - Wait for M_READY=0, then IDLE.
  - A requester still asserting REQ in the cycle DONE pulses must deassert it, or it is treated as a new request.
- Timeout: the counter resets on every state change and on every accepted beat. Reaching TIMEOUT in REQ, LOAD or STORE forces FIN with ERR.
  - In FIN, M_READY stuck high beyond TIMEOUT forces IDLE. No second DONE is issued.
- REQ deasserted mid-transaction is ignored; the transaction completes and DONE still pulses.
- Address and wdata changes after grant are ignored (latched copies are used).
- M_BEAT_VLD outside LOAD and M_WACK outside STORE are ignored.
- Beat counter is 3 bits; it does not wrap within a burst because the burst ends at index BURST_LEN-1.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state enum (IDLE, REQ, ADDR, LOAD, STORE, FIN)
  - BURST_LEN and block-offset width constants
  - port-id encoding (PORT_I=0, PORT_D=1)
  - the block-base alignment function
- One natural sub-module: mem_rr_arb, a 2-way round-robin grant with pointer update on a completion strobe.
- Timeout counter and FSM remain in the top level.

Test Plan:
- I_REQ, I_ADDR=0x0000_0044; memory returns beats 0..7 = 0xA0..0xA7 -> M_ADDR=0x40; eight I_RVALID pulses with RIDX 0..7 and data 0xA0..0xA7; then I_DONE=1 with ERR=0; D_RVALID never asserted.
- D_REQ, D_WE=1, D_ADDR=0x0000_0107, D_WDATA=0xDEADBEEF -> M_STORE=1, M_ADDR=0x104, M_WDATA=0xDEADBEEF; after M_WACK, D_DONE pulses once.
- I_REQ and D_REQ rise in the same cycle after reset, both held -> D served first, then I; pointer alternates over 4 back-to-back ties (D, I, D, I).
- Load burst where the memory sends index 3 when 2 is expected -> ERR and DONE pulse together; exactly beats 0,1 delivered; M_VALID falls the cycle after.
- M_READY never asserted with TIMEOUT=16 -> ERR+DONE pulse 17 cycles after M_VALID rises; back to IDLE once M_READY is low.
- RST_N pulled low during beat 4 of a burst -> all outputs 0 asynchronously; after release, a new I_REQ completes a full 8-beat burst normally.
